// File: rtl/vjtag_pkg.sv
// Shared constants, DR-operation encoding and IR decode helper for the
// virtual-JTAG register bank.
package vjtag_pkg;

  localparam int IR_BYPASS           = 0;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_CAPTURE,
    DR_SHIFT,
    DR_UPDATE
  } dr_op_e;

  // Maps a virtual IR value to a 0-based register index; -1 selects bypass.
  function automatic int ir_to_index(input int ir, input int numRegs);
    if (ir == IR_BYPASS || ir > numRegs) return -1;
    return ir - 1;
  endfunction

  function automatic dr_op_e decode_dr_op(input logic cdr, input logic sdr,
                                          input logic udr);
    if (cdr) return DR_CAPTURE;
    if (sdr) return DR_SHIFT;
    if (udr) return DR_UPDATE;
    return DR_IDLE;
  endfunction

endpackage

// File: rtl/vjtag_toggle_sync.sv
// Carries a tck-domain toggle into the clk domain and turns each transition
// into a single-cycle pulse.
module vjtag_toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic aclr,
  input  logic toggle_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], toggle_i};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_o = sync_q[STAGES-1] ^ edge_q;

endmodule

// File: rtl/vjtag_reg_bank.sv
// Virtual-JTAG data-register bank: scan-side shadows written from tck, then
// copied into clk-domain images on each synchronised update strobe.
module vjtag_reg_bank
  import vjtag_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int IR_W        = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                         tck,
  input  logic                         clk,
  input  logic                         aclr,
  input  logic                         tdi,
  input  logic [IR_W-1:0]              ir_in,
  input  logic                         v_cdr,
  input  logic                         v_sdr,
  input  logic                         v_udr,
  output logic                         tdo,
  output logic [NUM_REGS*DATA_W-1:0]   data_regs,
  output logic                         upd_valid,
  output logic [IR_W-1:0]              upd_index
);

  logic [DATA_W-1:0]          chain_q, chain_d;
  logic                       bypass_q;
  logic [DATA_W-1:0]          shadow_q [NUM_REGS];
  logic                       updToggle_q;
  logic [IR_W-1:0]            lastIdx_q;
  logic                       selValid;
  logic [IR_W-1:0]            selIdx;
  logic [DATA_W-1:0]          captureData;
  dr_op_e                     drOp;
  logic                       updPulse;
  logic [NUM_REGS*DATA_W-1:0] dataRegs_q;
  logic                       updValid_q;
  logic [IR_W-1:0]            updIndex_q;

  always_comb begin
    int idx;
    idx      = ir_to_index(int'(ir_in), NUM_REGS);
    selValid = (idx >= 0);
    selIdx   = selValid ? IR_W'(idx) : '0;
    drOp     = decode_dr_op(v_cdr, v_sdr, v_udr);

    captureData = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (selIdx == IR_W'(k)) captureData = shadow_q[k];

    chain_d = chain_q;
    if (selValid) begin
      case (drOp)
        DR_CAPTURE: chain_d = captureData;
        DR_SHIFT:   chain_d = {tdi, chain_q[DATA_W-1:1]};
        default:    chain_d = chain_q;
      endcase
    end
  end

  // The bypass bit runs every tck regardless of selection so that switching
  // to bypass mid-stream always presents the previous tdi bit.
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      chain_q     <= '0;
      bypass_q    <= 1'b0;
      updToggle_q <= 1'b0;
      lastIdx_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) shadow_q[k] <= '0;
    end else begin
      chain_q  <= chain_d;
      bypass_q <= tdi;
      if (selValid && drOp == DR_UPDATE) begin
        for (int k = 0; k < NUM_REGS; k++)
          if (selIdx == IR_W'(k)) shadow_q[k] <= chain_q;
        lastIdx_q   <= selIdx;
        updToggle_q <= ~updToggle_q;
      end
    end
  end

  assign tdo = selValid ? chain_q[0] : bypass_q;

  vjtag_toggle_sync #(
    .STAGES(SYNC_STAGES)
  ) uSync (
    .clk     (clk),
    .aclr    (aclr),
    .toggle_i(updToggle_q),
    .pulse_o (updPulse)
  );

  // Shadows and lastIdx are stable by the time the toggle edge emerges from
  // the synchroniser, so sampling them here is a safe crossing.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      dataRegs_q <= '0;
      updValid_q <= 1'b0;
      updIndex_q <= '0;
    end else begin
      updValid_q <= updPulse;
      if (updPulse) begin
        for (int k = 0; k < NUM_REGS; k++)
          dataRegs_q[k*DATA_W +: DATA_W] <= shadow_q[k];
        updIndex_q <= lastIdx_q;
      end
    end
  end

  assign data_regs = dataRegs_q;
  assign upd_valid = updValid_q;
  assign upd_index = updIndex_q;

endmodule

// File: tb/tb_vjtag_reg_bank.sv
// Self-checking bench for vjtag_reg_bank: directed scans plus randomized scans
// at three clock ratios, checked against an array model of the registers.
module tb_vjtag_reg_bank;

  localparam int DATA_W      = 8;
  localparam int NUM_REGS    = 4;
  localparam int IR_W        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TCK_HALF    = 40;

  logic                       tck   = 1'b0;
  logic                       clk   = 1'b0;
  logic                       aclr  = 1'b1;
  logic                       tdi   = 1'b0;
  logic [IR_W-1:0]            ir_in = '0;
  logic                       v_cdr = 1'b0;
  logic                       v_sdr = 1'b0;
  logic                       v_udr = 1'b0;
  logic                       tdo;
  logic [NUM_REGS*DATA_W-1:0] data_regs;
  logic                       upd_valid;
  logic [IR_W-1:0]            upd_index;

  int clkHalf    = 20;
  int compared   = 0;
  int mismatched = 0;
  int longCount  = 0;
  logic prevValid = 1'b0;
  int halves [3] = '{20, 120, 4};
  logic [DATA_W-1:0] multiVals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  logic [DATA_W-1:0]          model [NUM_REGS];
  logic [IR_W-1:0]            idxQ [$];
  logic [NUM_REGS*DATA_W-1:0] dataQ [$];

  vjtag_reg_bank #(
    .DATA_W     (DATA_W),
    .NUM_REGS   (NUM_REGS),
    .IR_W       (IR_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .tck      (tck),
    .clk      (clk),
    .aclr     (aclr),
    .tdi      (tdi),
    .ir_in    (ir_in),
    .v_cdr    (v_cdr),
    .v_sdr    (v_sdr),
    .v_udr    (v_udr),
    .tdo      (tdo),
    .data_regs(data_regs),
    .upd_valid(upd_valid),
    .upd_index(upd_index)
  );

  always #(TCK_HALF) tck = ~tck;
  always #(clkHalf) clk = ~clk;

  // Records every strobe seen in the clk domain and flags strobes wider than one cycle.
  always @(negedge clk) begin
    if (upd_valid) begin
      idxQ.push_back(upd_index);
      dataQ.push_back(data_regs);
      if (prevValid) longCount++;
    end
    prevValid = upd_valid;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] packModel();
    logic [NUM_REGS*DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_REGS; k++) w[k*DATA_W +: DATA_W] = model[k];
    return w;
  endfunction

  // One tck period starting at a falling edge: sample tdo, drive flags, wait.
  task automatic tckCycle(input logic cdr, input logic sdr, input logic udr,
                          input logic tdiBit, output logic tdoSeen);
    tdoSeen = tdo;
    v_cdr = cdr;
    v_sdr = sdr;
    v_udr = udr;
    tdi   = tdiBit;
    @(negedge tck);
  endtask

  task automatic waitStrobe(input string tag, input logic [IR_W-1:0] expIdx,
                            input logic [NUM_REGS*DATA_W-1:0] expData);
    int n;
    n = 0;
    while (idxQ.size() == 0 && n < 16) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_seen"}, 64'(idxQ.size() != 0), 64'd1);
    if (idxQ.size() != 0) begin
      checkOutput({tag, "_idx"}, 64'(idxQ.pop_front()), 64'(expIdx));
      checkOutput({tag, "_data"}, 64'(dataQ.pop_front()), 64'(expData));
    end
    repeat (5) @(negedge clk);
    #1;
    checkOutput({tag, "_single"}, 64'(idxQ.size()), 64'd0);
    idxQ.delete();
    dataQ.delete();
  endtask

  // Full DR scan: capture, shift data LSB first while reading old contents,
  // then optionally update; checks readback and the resulting strobe.
  task automatic applyStimulus(input string tag, input logic [IR_W-1:0] ir,
                               input logic [DATA_W-1:0] data, input logic doUpdate);
    logic [DATA_W-1:0] seen;
    logic [DATA_W-1:0] expRead;
    logic              bitSeen;
    logic              capBit;
    int                sel;
    sel    = (ir >= 1 && int'(ir) <= NUM_REGS) ? int'(ir) - 1 : -1;
    capBit = 1'($urandom);
    seen   = '0;
    @(negedge tck);
    ir_in = ir;
    tckCycle(1'b1, 1'b0, 1'b0, capBit, bitSeen);
    for (int i = 0; i < DATA_W; i++) begin
      tckCycle(1'b0, 1'b1, 1'b0, data[i], bitSeen);
      seen[i] = bitSeen;
    end
    expRead = (sel >= 0) ? model[sel] : {data[DATA_W-2:0], capBit};
    checkOutput({tag, "_tdo"}, 64'(seen), 64'(expRead));
    tckCycle(1'b0, 1'b0, doUpdate, 1'b0, bitSeen);
    tckCycle(1'b0, 1'b0, 1'b0, 1'b0, bitSeen);
    if (doUpdate && sel >= 0) begin
      model[sel] = data;
      waitStrobe(tag, IR_W'(sel), packModel());
    end else begin
      repeat (8) @(negedge clk);
      #1;
      checkOutput({tag, "_nostrobe"}, 64'(idxQ.size()), 64'd0);
      idxQ.delete();
      dataQ.delete();
    end
  endtask

  initial begin
    logic bitSeen;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

    $display("[TB] reset state");
    repeat (2) @(negedge tck);
    #3;
    checkOutput("rst_tdo", 64'(tdo), 64'd0);
    checkOutput("rst_valid", 64'(upd_valid), 64'd0);
    checkOutput("rst_index", 64'(upd_index), 64'd0);
    checkOutput("rst_data", 64'(data_regs), 64'd0);
    @(negedge tck);
    aclr = 1'b0;

    $display("[TB] directed scans");
    applyStimulus("wrA5", 4'd1, 8'hA5, 1'b1);
    applyStimulus("wr3C", 4'd3, 8'h3C, 1'b1);
    applyStimulus("rd3C", 4'd3, 8'h00, 1'b0);
    applyStimulus("rd3Cagain", 4'd3, 8'hFF, 1'b0);
    applyStimulus("byp0", 4'd0, 8'h0D, 1'b1);
    applyStimulus("byp7", 4'd7, 8'h0D, 1'b1);
    for (int r = 0; r < NUM_REGS; r++)
      applyStimulus($sformatf("multi%0d", r), IR_W'(r + 1), multiVals[r], 1'b1);
    checkOutput("multiFinal", 64'(data_regs), 64'h44332211);

    $display("[TB] reset mid-scan");
    @(negedge tck);
    ir_in = 4'd2;
    tckCycle(1'b1, 1'b0, 1'b0, 1'b0, bitSeen);
    repeat (4) tckCycle(1'b0, 1'b1, 1'b0, 1'b1, bitSeen);
    aclr  = 1'b1;
    v_sdr = 1'b0;
    #3;
    checkOutput("midRst_tdo", 64'(tdo), 64'd0);
    checkOutput("midRst_valid", 64'(upd_valid), 64'd0);
    checkOutput("midRst_index", 64'(upd_index), 64'd0);
    checkOutput("midRst_data", 64'(data_regs), 64'd0);
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    @(negedge tck);
    aclr = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("midRst_nostrobe", 64'(idxQ.size()), 64'd0);
    idxQ.delete();
    dataQ.delete();
    applyStimulus("postRst", 4'd2, 8'h5A, 1'b1);

    $display("[TB] randomized scans at three clock ratios");
    for (int p = 0; p < 3; p++) begin
      clkHalf = halves[p];
      repeat (3) @(negedge clk);
      for (int i = 0; i < 10; i++)
        applyStimulus($sformatf("rnd%0d_%0d", p, i), IR_W'($urandom_range(0, 7)),
                      DATA_W'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    checkOutput("longStrobe", 64'(longCount), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
